// File: rtl/echo_pkg.sv
// Shared types and helpers for the echo delay line: slot record, default widths, tap arithmetic.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package echo_pkg;

    localparam int ECHO_DEPTH   = 16;
    localparam int ECHO_TIMER_W = 22;
    localparam int ECHO_NOTE_W  = 7;
    localparam int ECHO_VEL_W   = 4;
    localparam int ECHO_PB_W    = 9;
    localparam int ECHO_REP_W   = 3;

    // One stored event. 'vel' always holds the velocity of the next tap to be emitted,
    // 'due' the timestamp of that tap, 'left' the number of taps still to come.
    typedef struct packed {
        logic                    valid;
        logic                    on;
        logic [ECHO_NOTE_W-1:0]  note;
        logic [ECHO_VEL_W-1:0]   vel;
        logic [ECHO_PB_W-1:0]    pb;
        logic [ECHO_TIMER_W-1:0] due;
        logic [ECHO_TIMER_W-1:0] step;
        logic [ECHO_REP_W-1:0]   left;
    } slot_t;

    // Note-on taps lose 'decay' each time but never reach 0 (a zero velocity would read
    // as a note-off downstream). Note-off taps repeat their velocity unchanged.
    function automatic logic [ECHO_VEL_W-1:0] vel_decay(
        input logic                  on,
        input logic [ECHO_VEL_W-1:0] vel,
        input logic [ECHO_VEL_W-1:0] decay
    );
        logic [ECHO_VEL_W-1:0] r;
        if (!on)
            r = vel;
        else if (vel > decay)
            r = vel - decay;
        else
            r = ECHO_VEL_W'(1);
        return r;
    endfunction

    // Wrap-safe "has the timer reached 'due'": the modular distance now-due lies in the
    // lower half of the range once due has been reached or passed.
    function automatic logic due_reached(
        input logic [ECHO_TIMER_W-1:0] now,
        input logic [ECHO_TIMER_W-1:0] due
    );
        logic [ECHO_TIMER_W-1:0] diff;
        diff = now - due;
        return ~diff[ECHO_TIMER_W-1];
    endfunction

endpackage

// File: rtl/echo_prio_enc.sv
// Lowest-index priority encoder: reports whether any request bit is set and the lowest set index.
// Latency: purely combinational.
// Backpressure: none.
// Ports: req (DEPTH request bits) -> found (any bit set), idx (lowest set bit, 0 when none).
module echo_prio_enc #(
    parameter int DEPTH = 16,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] req,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    // Scan from the top down so the last hit written is the lowest index.
    always_comb begin
        found = |req;
        idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (req[i])
                idx = IDX_W'(i);
        end
    end

endmodule

// File: rtl/echo_delay_line.sv
// Multi-tap MIDI echo: captures note events into slots and replays each 'repeats' times, DELAY ticks apart, with decaying velocity.
// Latency: capture to out_valid is delay+1 cycles when the output register is idle (delay=0 behaves as 1).
// Backpressure: out_valid & !out_ready holds the output stable and stalls further loads; full slot table drops input and sets sticky overflow.
//
// Optional feature: define ECHO_CHANGE_DETECT_EN to ignore in_valid and strobe internally whenever
// {in_on,in_note,in_vel,in_pb} differs from the last strobed copy.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   en                    tick enable (freezes timer, capture and load when low)
//   delay/decay/repeats   per-event echo shape, sampled at capture (decay also at each re-arm)
//   in_valid/in_on/in_note/in_vel/in_pb   input event, in_ready = a slot is free
//   out_valid/out_ready/out_on/out_note/out_vel/out_pb   echo event handshake and fields
//   overflow              sticky flag: an event was lost because every slot was busy
//
// Field widths are tied to echo_pkg::slot_t; change them in the package, DEPTH is free.
module echo_delay_line
    import echo_pkg::*;
#(
    parameter int DEPTH   = ECHO_DEPTH,
    parameter int TIMER_W = ECHO_TIMER_W,
    parameter int NOTE_W  = ECHO_NOTE_W,
    parameter int VEL_W   = ECHO_VEL_W,
    parameter int PB_W    = ECHO_PB_W,
    parameter int REP_W   = ECHO_REP_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               en,
    input  logic [TIMER_W-1:0] delay,
    input  logic [VEL_W-1:0]   decay,
    input  logic [REP_W-1:0]   repeats,
    input  logic               in_valid,
    input  logic               in_on,
    input  logic [NOTE_W-1:0]  in_note,
    input  logic [VEL_W-1:0]   in_vel,
    input  logic [PB_W-1:0]    in_pb,
    output logic               in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_on,
    output logic [NOTE_W-1:0]  out_note,
    output logic [VEL_W-1:0]   out_vel,
    output logic [PB_W-1:0]    out_pb,
    output logic               overflow
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [TIMER_W-1:0] timer;
    slot_t              slots [DEPTH];

    logic [DEPTH-1:0]   free_map;
    logic [DEPTH-1:0]   due_map;
    logic               free_found;
    logic [IDX_W-1:0]   free_idx;
    logic               due_found;
    logic [IDX_W-1:0]   due_idx;

    logic               strobe;
    logic               want_cap;
    logic               capture;
    logic               load;
    logic [TIMER_W-1:0] eff_delay;
    slot_t              new_slot;
    slot_t              ld_slot;

    always_comb begin
        free_map = '0;
        due_map  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            free_map[i] = ~slots[i].valid;
            due_map[i]  = slots[i].valid & due_reached(timer, slots[i].due);
        end
    end

    echo_prio_enc #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_free_enc (
        .req   (free_map),
        .found (free_found),
        .idx   (free_idx)
    );

    echo_prio_enc #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_due_enc (
        .req   (due_map),
        .found (due_found),
        .idx   (due_idx)
    );

`ifdef ECHO_CHANGE_DETECT_EN
    logic              last_on;
    logic [NOTE_W-1:0] last_note;
    logic [VEL_W-1:0]  last_vel;
    logic [PB_W-1:0]   last_pb;
    logic              unused_in_valid;

    assign unused_in_valid = in_valid;
    assign strobe = {in_on, in_note, in_vel, in_pb} != {last_on, last_note, last_vel, last_pb};

    // The copy follows every strobe, including dropped ones, so a held input never re-fires.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_on   <= 1'b0;
            last_note <= '0;
            last_vel  <= '0;
            last_pb   <= '0;
        end else if (en && strobe) begin
            last_on   <= in_on;
            last_note <= in_note;
            last_vel  <= in_vel;
            last_pb   <= in_pb;
        end
    end
`else
    assign strobe = in_valid;
`endif

    assign in_ready  = free_found;
    assign want_cap  = en & strobe & (repeats != '0);
    assign capture   = want_cap & free_found;
    assign load      = en & due_found & (~out_valid | out_ready);
    assign eff_delay = (delay == '0) ? TIMER_W'(1) : delay;
    assign ld_slot   = slots[due_idx];

    always_comb begin
        new_slot       = '0;
        new_slot.valid = 1'b1;
        new_slot.on    = in_on;
        new_slot.note  = in_note;
        new_slot.vel   = vel_decay(in_on, in_vel, decay);
        new_slot.pb    = in_pb;
        new_slot.due   = timer + eff_delay;
        new_slot.step  = eff_delay;
        new_slot.left  = repeats;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            timer <= '0;
        else if (en)
            timer <= timer + TIMER_W'(1);
    end

    // Capture and load never target the same slot (free vs. valid), so one pass covers both.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++)
                slots[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (capture && free_idx == IDX_W'(i)) begin
                    slots[i] <= new_slot;
                end else if (load && due_idx == IDX_W'(i)) begin
                    if (slots[i].left > ECHO_REP_W'(1)) begin
                        slots[i].left <= slots[i].left - ECHO_REP_W'(1);
                        slots[i].due  <= slots[i].due + slots[i].step;
                        slots[i].vel  <= vel_decay(slots[i].on, slots[i].vel, decay);
                    end else begin
                        slots[i].valid <= 1'b0;
                    end
                end
            end
        end
    end

    // The handshake may complete while en is low; only new loads wait for en.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_on    <= 1'b0;
            out_note  <= '0;
            out_vel   <= '0;
            out_pb    <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_on    <= ld_slot.on;
            out_note  <= ld_slot.note;
            out_vel   <= ld_slot.vel;
            out_pb    <= ld_slot.pb;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            overflow <= 1'b0;
        else if (want_cap && !free_found)
            overflow <= 1'b1;
    end

endmodule
